adc_scan_sequencer: RTL and testbench
=====================================

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_CH, 8, number of logical ADC channels (1..16); TIMEOUT, 255, max sys_clk cycles to wait for a response after command accept.
REQ-002 sys_clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 enable  in  1  scanning permitted while high.
REQ-005 ch_mask  in  NUM_CH  bit i=1 includes logical channel i in the scan.
REQ-006 cmd_valid  out  1  / cmd_channel  out  5  / cmd_ready  in  1: ADC command handshake.
REQ-007 rsp_valid  in  1  / rsp_channel  in  5  / rsp_data  in  12: ADC response stream.
REQ-008 sample_data  out  12*NUM_CH  latest sample per channel; channel i at bits [12i+11:12i].
REQ-009 sample_fresh  out  NUM_CH  bit i set on new sample for channel i; fresh_ack  in  NUM_CH  clears bits.
REQ-010 sample_strobe  out  1  / sample_ch  out  5  / sample_value  out  12: one-cycle report of each accepted sample.
REQ-011 scan_done  out  1  one-cycle pulse at end of each pass; busy  out  1  high in any state other than IDLE.
REQ-012 timeout_err  out  1  sticky error flag; clr_err  in  1  clears it.

Function
REQ-013 Channel mapping SHALL be: cmd_channel = logical index + 1; response matches when rsp_channel = current logical index + 1.
REQ-014 FSM states SHALL be IDLE, SELECT, CMD, WAIT_RSP.
REQ-015 IDLE -> SELECT when enable=1 and ch_mask!=0; otherwise remain in IDLE.
REQ-016 SELECT (exactly one cycle) SHALL pick the lowest enabled index above the last-served index, wrapping to the lowest enabled index; -> CMD. If ch_mask=0 on that cycle -> IDLE.
REQ-017 CMD: cmd_valid=1, cmd_channel held stable until the cycle with cmd_ready=1; that handshake cycle -> WAIT_RSP, timer cleared to 0. cmd_valid SHALL be 0 in all other states.
REQ-018 WAIT_RSP: timer increments by 1 per cycle; rsp_valid with matching rsp_channel completes the channel; rsp_valid with non-matching channel SHALL be ignored.
REQ-019 On completion, the next cycle SHALL have: sample_data slice updated to rsp_data, sample_fresh bit set, sample_strobe=1, sample_ch=logical index, sample_value=rsp_data (one-cycle latency).
REQ-020 When timer reaches TIMEOUT with no matching response: timeout_err set, no sample update, channel counted as served.
REQ-021 After completion or timeout: -> SELECT if enable=1 and ch_mask!=0, else -> IDLE.
REQ-022 scan_done SHALL pulse in the completion/timeout cycle when ch_mask contains no enabled index above the served one.
REQ-023 Mid-transaction enable deassert or ch_mask change SHALL NOT abort CMD or WAIT_RSP; new values take effect at next SELECT/IDLE decision.
REQ-024 Same-cycle sample set and fresh_ack on one bit: set wins; same-cycle timeout and clr_err: set wins.
REQ-025 Only one command SHALL be outstanding at any time.

Reset
REQ-026 On reset: state=IDLE, last-served index=NUM_CH-1 (first pick is lowest enabled), timer=0, all outputs 0 including sample_data, sample_fresh, timeout_err.
REQ-027 Reset asserted in any state SHALL return to IDLE on the next edge, dropping cmd_valid and discarding any outstanding response.

Verification
REQ-028 ch_mask=8'h05, enable=1, cmd_ready=1, ADC echoes channel with data 12'hABC after 3 cycles -> commands for cmd_channel 1,3,1,3...; sample_ch 0 then 2; scan_done after ch2.
REQ-029 cmd_ready held 0 for 10 cycles in CMD -> cmd_valid=1 and cmd_channel constant throughout; WAIT_RSP entered only after ready.
REQ-030 No response after accept, TIMEOUT=255 -> timeout_err=1 on cycle 255, sample_fresh unchanged, sequencer moves to next channel; clr_err clears it.
REQ-031 Response with rsp_channel=5 while waiting for channel 1 -> ignored, no strobe; later rsp_channel=2 -> accepted.
REQ-032 enable dropped during WAIT_RSP -> response still captured, then IDLE with busy=0; fresh_ack with simultaneous update -> bit stays 1.
REQ-033 reset pulsed during CMD -> next cycle cmd_valid=0, all outputs 0, state IDLE.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin ADC channel scanner with per-channel sample store and response timeout
module adc_scan_sequencer #(
    parameter int NUM_CH  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_CH-1:0]      ch_mask,
    output logic                   cmd_valid,
    output logic [4:0]             cmd_channel,
    input  logic                   cmd_ready,
    input  logic                   rsp_valid,
    input  logic [4:0]             rsp_channel,
    input  logic [11:0]            rsp_data,
    output logic [12*NUM_CH-1:0]   sample_data,
    output logic [NUM_CH-1:0]      sample_fresh,
    input  logic [NUM_CH-1:0]      fresh_ack,
    output logic                   sample_strobe,
    output logic [4:0]             sample_ch,
    output logic [11:0]            sample_value,
    output logic                   scan_done,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   clr_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, SELECT, CMD, WAIT_RSP} state_t;
    state_t                 state_q, state_d;
    logic [3:0]             ch_q, ch_d, lo_idx, hi_idx;
    logic                   hi_found, match, timed_out, fin;
    logic [TW-1:0]          timer_q, timer_d;
    logic [12*NUM_CH-1:0]   sample_data_q, sample_data_d;
    logic [NUM_CH-1:0]      sample_fresh_q, sample_fresh_d, set_vec;
    logic                   timeout_err_q, timeout_err_d;
    logic                   sample_strobe_q, sample_strobe_d;
    logic [4:0]             sample_ch_q, sample_ch_d;
    logic [11:0]            sample_value_q, sample_value_d;
    // ch_q doubles as the last-served index: only reset can abandon a channel
    always_comb begin
        lo_idx   = ch_q;
        hi_idx   = ch_q;
        hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                lo_idx = 4'(i);
                if (4'(i) > ch_q) begin
                    hi_idx   = 4'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end
    assign match       = state_q == WAIT_RSP && rsp_valid && rsp_channel == {1'b0, ch_q} + 5'd1;
    assign timed_out   = state_q == WAIT_RSP && !match && timer_q == TW'(TIMEOUT - 1);
    assign fin         = match || timed_out;
    assign scan_done   = fin && !hi_found && !reset;
    assign cmd_valid   = state_q == CMD;
    assign cmd_channel = cmd_valid ? {1'b0, ch_q} + 5'd1 : 5'd0;
    assign busy        = state_q != IDLE;
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        timer_d = timer_q;
        case (state_q)
            IDLE:     state_d = (enable && |ch_mask) ? SELECT : IDLE;
            SELECT: begin
                state_d = |ch_mask ? CMD : IDLE;
                ch_d    = hi_found ? hi_idx : lo_idx;
            end
            CMD: begin
                state_d = cmd_ready ? WAIT_RSP : CMD;
                timer_d = '0;
            end
            WAIT_RSP: begin
                timer_d = timer_q + 1'b1;
                state_d = !fin ? WAIT_RSP : (enable && |ch_mask) ? SELECT : IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end
    always_comb begin
        sample_data_d = sample_data_q;
        set_vec       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (match && ch_q == 4'(i)) begin
                sample_data_d[12*i +: 12] = rsp_data;
                set_vec[i]                = 1'b1;
            end
        end
        sample_fresh_d  = (sample_fresh_q & ~fresh_ack) | set_vec;
        timeout_err_d   = timed_out | (timeout_err_q & ~clr_err);
        sample_strobe_d = match;
        sample_ch_d     = match ? {1'b0, ch_q} : 5'd0;
        sample_value_d  = match ? rsp_data : 12'd0;
    end
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q         <= IDLE;
            ch_q            <= 4'(NUM_CH - 1);
            timer_q         <= '0;
            sample_data_q   <= '0;
            sample_fresh_q  <= '0;
            timeout_err_q   <= 1'b0;
            sample_strobe_q <= 1'b0;
            sample_ch_q     <= '0;
            sample_value_q  <= '0;
        end else begin
            state_q         <= state_d;
            ch_q            <= ch_d;
            timer_q         <= timer_d;
            sample_data_q   <= sample_data_d;
            sample_fresh_q  <= sample_fresh_d;
            timeout_err_q   <= timeout_err_d;
            sample_strobe_q <= sample_strobe_d;
            sample_ch_q     <= sample_ch_d;
            sample_value_q  <= sample_value_d;
        end
    end
    assign sample_data   = sample_data_q;
    assign sample_fresh  = sample_fresh_q;
    assign timeout_err   = timeout_err_q;
    assign sample_strobe = sample_strobe_q;
    assign sample_ch     = sample_ch_q;
    assign sample_value  = sample_value_q;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: scoreboard bench driving an ADC model against adc_scan_sequencer
module tb_adc_scan_sequencer;
    localparam int NUM_CH = 8;
    logic                 sys_clk, reset, enable, cmd_valid, cmd_ready, rsp_valid;
    logic                 sample_strobe, scan_done, busy, timeout_err, clr_err;
    logic [NUM_CH-1:0]    ch_mask, sample_fresh, fresh_ack;
    logic [4:0]           cmd_channel, rsp_channel, sample_ch;
    logic [11:0]          rsp_data, sample_value;
    logic [12*NUM_CH-1:0] sample_data;
    logic [16:0]          exp_q[$];
    logic [16:0]          mon_e;
    int                   n_chk = 0, n_fail = 0;

    adc_scan_sequencer #(.NUM_CH(NUM_CH), .TIMEOUT(255)) dut (
        .sys_clk(sys_clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
        .sample_data(sample_data), .sample_fresh(sample_fresh), .fresh_ack(fresh_ack),
        .sample_strobe(sample_strobe), .sample_ch(sample_ch), .sample_value(sample_value),
        .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sample_strobe) begin
            if (exp_q.size() == 0) check("spurious_strobe", 32'(sample_strobe), 0);
            else begin
                mon_e = exp_q.pop_front();
                check("sample_ch", 32'(sample_ch), 32'(mon_e[16:12]));
                check("sample_value", 32'(sample_value), 32'(mon_e[11:0]));
                check("sample_data", 32'(sample_data[12*int'(mon_e[16:12]) +: 12]), 32'(mon_e[11:0]));
                check("fresh_set", 32'(sample_fresh[mon_e[16:12]]), 1);
            end
        end
    end

    task automatic wait_cmd(input logic [4:0] exp_cmd);
        int n = 0;
        while (!cmd_valid && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        check("cmd_seen", 32'(cmd_valid), 1);
        check("cmd_channel", 32'(cmd_channel), 32'(exp_cmd));
    endtask

    task automatic serve(input logic [4:0] exp_cmd, input int ready_wait, input int delay,
                         input logic [11:0] data, input logic exp_done, input logic drop_en,
                         input logic [NUM_CH-1:0] ack, input logic bogus);
        wait_cmd(exp_cmd);
        repeat (ready_wait) begin
            @(negedge sys_clk);
            check("cmd_hold", 32'({cmd_valid, cmd_channel}), 32'({1'b1, exp_cmd}));
        end
        cmd_ready = 1'b1;
        @(negedge sys_clk);
        cmd_ready = 1'b0;
        if (drop_en) enable = 1'b0;
        check("cmd_drop", 32'(cmd_valid), 0);
        check("busy_wait", 32'(busy), 1);
        if (bogus) begin
            rsp_valid   = 1'b1;
            rsp_channel = 5'd5;
            rsp_data    = 12'hBAD;
            @(negedge sys_clk);
            rsp_valid = 1'b0;
            check("bogus_strobe", 32'(sample_strobe), 0);
        end
        repeat (delay) @(negedge sys_clk);
        rsp_valid   = 1'b1;
        rsp_channel = exp_cmd;
        rsp_data    = data;
        fresh_ack   = ack;
        exp_q.push_back({exp_cmd - 5'd1, data});
        #1 check("scan_done", 32'(scan_done), 32'(exp_done));
        @(negedge sys_clk);
        rsp_valid = 1'b0;
        fresh_ack = '0;
    endtask

    task automatic timeout_run(input logic [4:0] exp_cmd, input logic [NUM_CH-1:0] exp_fresh);
        wait_cmd(exp_cmd);
        cmd_ready = 1'b1;
        @(negedge sys_clk);
        cmd_ready = 1'b0;
        repeat (254) @(negedge sys_clk);
        check("err_early", 32'(timeout_err), 0);
        check("timeout_done", 32'(scan_done), 1);
        @(negedge sys_clk);
        check("err_set", 32'(timeout_err), 1);
        check("fresh_kept", 32'(sample_fresh), 32'(exp_fresh));
        check("timeout_strobe", 32'(sample_strobe), 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
        check({tag, "_cmd_channel"}, 32'(cmd_channel), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_fresh"}, 32'(sample_fresh), 0);
        check({tag, "_err"}, 32'(timeout_err), 0);
        check({tag, "_strobe"}, 32'(sample_strobe), 0);
        check({tag, "_done"}, 32'(scan_done), 0);
        check({tag, "_data"}, 32'(|sample_data), 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; ch_mask = '0; cmd_ready = 1'b0; rsp_valid = 1'b0;
        rsp_channel = '0; rsp_data = '0; fresh_ack = '0; clr_err = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_cleared("reset");
        reset = 1'b0; ch_mask = 8'h05; enable = 1'b1;
        serve(5'd1, 0, 3, 12'hABC, 1'b0, 1'b0, '0, 1'b0);
        serve(5'd3, 0, 3, 12'hABC, 1'b1, 1'b0, '0, 1'b0);
        serve(5'd1, 0, 3, 12'h321, 1'b0, 1'b0, '0, 1'b0);
        serve(5'd3, 0, 3, 12'h456, 1'b1, 1'b0, '0, 1'b0);
        serve(5'd1, 10, 2, 12'h789, 1'b0, 1'b0, '0, 1'b0);
        serve(5'd3, 0, 2, 12'h5A5, 1'b1, 1'b1, 8'hFF, 1'b0);
        repeat (2) @(negedge sys_clk);
        check("idle_busy", 32'(busy), 0);
        check("ack_vs_set", 32'(sample_fresh), 32'h04);
        ch_mask = 8'h02; enable = 1'b1;
        serve(5'd2, 0, 2, 12'h0F0, 1'b1, 1'b0, '0, 1'b1);
        ch_mask = 8'h06;
        timeout_run(5'd3, 8'h06);
        clr_err = 1'b1;
        @(negedge sys_clk);
        clr_err = 1'b0;
        check("err_cleared", 32'(timeout_err), 0);
        serve(5'd2, 0, 1, 12'h3C3, 1'b0, 1'b0, '0, 1'b0);
        wait_cmd(5'd3);
        reset = 1'b1;
        @(negedge sys_clk);
        check_cleared("mid_reset");
        reset = 1'b0;
        serve(5'd2, 0, 2, 12'hFED, 1'b0, 1'b0, '0, 1'b0);
        enable = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
